// File: rtl/jk_sched_pkg.sv
// rtl/jk_sched_pkg.sv - shared op codes, FSM encoding and J/K decode for the JK bank scheduler
package jk_sched_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } sched_state_t;

  // Returns {J, K} for the addressed cell.
  function automatic logic [1:0] jk_of_op(input logic [1:0] op);
    logic [1:0] jk;
    case (op)
      OP_SET:  jk = 2'b10;
      OP_CLR:  jk = 2'b01;
      OP_TGL:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_bank_scheduler_if.sv
// rtl/jk_bank_scheduler_if.sv - requester/bank bus between control agents and the JK bank scheduler
interface jk_bank_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
);
  logic [NREQ-1:0]      REQ;
  logic [NREQ-1:0]      LOCK;
  logic [2*NREQ-1:0]    OP;
  logic [IDXW*NREQ-1:0] IDX;
  logic [NREQ-1:0]      GNT;
  logic                 ERR;
  logic [WIDTH-1:0]     Q;
  logic [WIDTH-1:0]     QN;

  modport master (output REQ, LOCK, OP, IDX, input GNT, ERR, Q, QN);
  modport slave  (input REQ, LOCK, OP, IDX, output GNT, ERR, Q, QN);
endinterface

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with synchronous active-high reset
module jk_cell (
  input  logic CLK,
  input  logic RST,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic QN
);
  logic r_q;

  always_ff @(posedge CLK) begin
    if (RST) r_q <= 1'b0;
    else     r_q <= (J & ~r_q) | (~K & r_q);
  end

  assign Q  = r_q;
  assign QN = ~r_q;
endmodule

// File: rtl/jk_bank_scheduler.sv
// rtl/jk_bank_scheduler.sv - round-robin, lockable scheduler applying one JK op per cycle to a flag bank
import jk_sched_pkg::*;

module jk_bank_scheduler #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int IDXW     = 3,
  parameter int MAX_LOCK = 4
) (
  input logic                CLK,
  input logic                RST,
  jk_bank_scheduler_if.slave bus
);
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LCW = $clog2(MAX_LOCK + 1);

  sched_state_t    r_state;
  logic [PW-1:0]   r_ptr;
  logic [LCW-1:0]  r_lock_cnt;
  logic            r_cmd_valid;
  logic [1:0]      r_cmd_op;
  logic [IDXW-1:0] r_cmd_idx;
  logic [NREQ-1:0] r_gnt;
  logic            r_err;

  logic            w_any;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_win_next;
  logic [1:0]      w_sel_op;
  logic [IDXW-1:0] w_sel_idx;
  logic            w_lock;
  logic            w_held;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qn;

  function automatic int rr_idx(input int p, input int k);
    return (p + k) % NREQ;
  endfunction

  // While locked the pointer sits on the owner, so a plain search from the
  // pointer grants the owner first and otherwise falls through to owner+1.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && bus.REQ[rr_idx(int'(r_ptr), k)]) begin
        w_any = 1'b1;
        w_win = PW'(rr_idx(int'(r_ptr), k));
      end
    end
  end

  assign w_sel_op   = bus.OP[2*int'(w_win) +: 2];
  assign w_sel_idx  = bus.IDX[IDXW*int'(w_win) +: IDXW];
  assign w_lock     = bus.LOCK[w_win];
  assign w_win_next = (int'(w_win) == NREQ - 1) ? '0 : w_win + PW'(1);
  assign w_held     = (r_state == ST_LOCKED) && bus.REQ[r_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_ARB;
      r_ptr       <= '0;
      r_lock_cnt  <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= OP_HOLD;
      r_cmd_idx   <= '0;
      r_gnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_cmd_valid <= w_any;
      r_gnt       <= '0;
      r_err       <= 1'b0;
      if (w_any) begin
        r_gnt     <= NREQ'(1) << w_win;
        r_err     <= int'(w_sel_idx) >= WIDTH;
        r_cmd_op  <= w_sel_op;
        r_cmd_idx <= w_sel_idx;
      end
      if (w_held) begin
        if (!w_lock || (int'(r_lock_cnt) + 1 >= MAX_LOCK)) begin
          r_ptr      <= w_win_next;
          r_lock_cnt <= '0;
          r_state    <= ST_ARB;
        end else begin
          r_lock_cnt <= r_lock_cnt + LCW'(1);
        end
      end else begin
        r_state    <= ST_ARB;
        r_lock_cnt <= '0;
        if (w_any) begin
          if (w_lock && (MAX_LOCK > 1)) begin
            r_ptr      <= w_win;
            r_lock_cnt <= LCW'(1);
            r_state    <= ST_LOCKED;
          end else begin
            r_ptr <= w_win_next;
          end
        end
      end
    end
  end

  // Out-of-range indices match no cell, so the bank is left untouched.
  always_comb begin
    w_j = '0;
    w_k = '0;
    for (int c = 0; c < WIDTH; c++) begin
      if (r_cmd_valid && (int'(r_cmd_idx) == c)) begin
        {w_j[c], w_k[c]} = jk_of_op(r_cmd_op);
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .CLK (CLK),
      .RST (RST),
      .J   (w_j[g]),
      .K   (w_k[g]),
      .Q   (w_q[g]),
      .QN  (w_qn[g])
    );
  end

  assign bus.Q   = w_q;
  assign bus.QN  = w_qn;
  assign bus.GNT = r_gnt;
  assign bus.ERR = r_err;
endmodule

// File: tb/tb_jk_bank_scheduler.sv
// tb/tb_jk_bank_scheduler.sv - scoreboard bench for jk_bank_scheduler with directed vectors
module tb_jk_bank_scheduler;
  import jk_sched_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  jk_bank_scheduler_if #(.NREQ(4), .WIDTH(8), .IDXW(4)) bus ();

  jk_bank_scheduler #(.NREQ(4), .WIDTH(8), .IDXW(4), .MAX_LOCK(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Scoreboard monitor: every GNT/ERR pulse must match the next queued expectation.
  always @(negedge CLK) begin
    if (bus.GNT != 4'b0 || bus.ERR) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_gnt: got gnt=%b err=%b, required no grant", bus.GNT, bus.ERR);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({bus.GNT, bus.ERR} !== e) begin
          errors++;
          $display("FAIL gnt_err: got gnt=%b err=%b, required gnt=%b err=%b",
                   bus.GNT, bus.ERR, e[4:1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_op(input int r, input logic [1:0] op, input logic [3:0] idx,
                       input logic err, input logic [7:0] q_exp, input string nm);
    exp_q.push_back({4'(1 << r), err});
    bus.REQ = '0;
    bus.REQ[r] = 1'b1;
    bus.OP[2*r +: 2] = op;
    bus.IDX[4*r +: 4] = idx;
    tick();
    bus.REQ = '0;
    tick();
    chk({nm, "_q"}, bus.Q, q_exp);
    chk({nm, "_qn"}, bus.QN, ~q_exp);
  endtask

  initial begin
    bus.REQ = '0; bus.LOCK = '0; bus.OP = '0; bus.IDX = '0;
    RST = 1'b1;
    tick();
    for (int n = 0; n < 2; n++) begin
      bus.REQ = 4'($urandom); bus.LOCK = 4'($urandom);
      bus.OP = 8'($urandom); bus.IDX = 16'($urandom);
      tick();
      chk("rst_q", bus.Q, 8'h00);
      chk("rst_qn", bus.QN, 8'hFF);
      chk("rst_gnt", {4'b0, bus.GNT}, 8'h00);
      chk("rst_err", {7'b0, bus.ERR}, 8'h00);
    end
    bus.REQ = '0; bus.LOCK = '0; bus.OP = '0; bus.IDX = '0;
    RST = 1'b0;
    tick();

    do_op(1, OP_SET,  4'd5, 1'b0, 8'h20, "set5");
    do_op(1, OP_TGL,  4'd5, 1'b0, 8'h00, "tgl5");
    do_op(2, OP_SET,  4'd3, 1'b0, 8'h08, "set3");
    do_op(2, OP_HOLD, 4'd3, 1'b0, 8'h08, "hold3");
    do_op(3, OP_CLR,  4'd3, 1'b0, 8'h00, "clr3");

    exp_q.push_back(5'b0001_0); exp_q.push_back(5'b0010_0);
    exp_q.push_back(5'b0100_0); exp_q.push_back(5'b1000_0);
    exp_q.push_back(5'b0001_0);
    bus.OP = 8'hFF; bus.IDX = 16'h3210; bus.REQ = 4'hF;
    repeat (5) @(posedge CLK);
    #1 bus.REQ = '0;
    tick();
    chk("rr_q", bus.Q, 8'h0E);

    do_op(3, OP_HOLD, 4'd0, 1'b0, 8'h0E, "hold_ptr");

    repeat (4) exp_q.push_back(5'b0001_0);
    exp_q.push_back(5'b0010_0);
    exp_q.push_back(5'b0001_0);
    bus.OP = '0; bus.REQ = 4'b0011; bus.LOCK = 4'b0001;
    repeat (6) @(posedge CLK);
    #1 bus.REQ = '0; bus.LOCK = '0;
    tick();
    chk("lock_q", bus.Q, 8'h0E);

    do_op(2, OP_SET, 4'd9, 1'b1, 8'h0E, "err9");
    do_op(3, OP_SET, 4'd7, 1'b0, 8'h8E, "set7");
    do_op(0, OP_TGL, 4'd8, 1'b1, 8'h8E, "err8");

    exp_q.push_back(5'b0001_0);
    bus.REQ = 4'b0001; bus.OP[1:0] = OP_SET; bus.IDX[3:0] = 4'd2;
    tick();
    bus.REQ = '0; RST = 1'b1;
    tick();
    chk("midrst_q", bus.Q, 8'h00);
    chk("midrst_qn", bus.QN, 8'hFF);
    chk("midrst_gnt", {4'b0, bus.GNT}, 8'h00);
    RST = 1'b0;
    repeat (3) tick();
    chk("no_late_set", bus.Q, 8'h00);

    exp_q.push_back(5'b0001_0);
    bus.OP = '0; bus.REQ = 4'hF;
    tick();
    bus.REQ = '0;
    repeat (2) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_gnt: got %0d grants outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
